router_pkt_tx: RTL

Packet transmitter for the 1x3 router input port. It collects a payload from a local byte stream into an internal buffer, then sends a complete router packet to the router's input interface: a header byte, 1–63 payload bytes, then an even-parity byte. It honours the router's `busy` back-pressure. It sits upstream of the router's input FSM and register and serves as both the source block and the bench stimulus driver.

---
 rtl/router_pkg.sv | 24 ++
 rtl/tx_payload_buf.sv | 18 +
 rtl/router_pkt_tx.sv | 113 +++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared header layout, address constants and transmitter state encoding.
package router_pkg;
  localparam int LEN_W = 6;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB = 2;
  localparam int LEN_MSB = 7;
  localparam logic [1:0] INVALID_ADDR = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_DONE
  } state_t;
  function automatic logic [7:0] make_header(input logic [1:0] addr, input logic [LEN_W-1:0] len);
    logic [7:0] h;
    h = '0;
    h[ADDR_MSB:ADDR_LSB] = addr;
    h[LEN_MSB:LEN_LSB] = len;
    return h;
  endfunction
endpackage

// File: rtl/tx_payload_buf.sv
// tx_payload_buf: payload register file, synchronous write, asynchronous read, no storage reset.
module tx_payload_buf #(
  parameter int MAX_LEN = 63,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  logic [7:0] mem [MAX_LEN];
  always_ff @(posedge clk)
    if (wr_en && wr_addr < AW'(MAX_LEN)) mem[wr_addr] <= wr_data;
  // the counter parks at len after the last byte, which may be one past the end
  assign rd_data = rd_addr < AW'(MAX_LEN) ? mem[rd_addr] : '0;
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a payload, then sends header, payload and parity to the router with busy back-pressure.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic       busy,
  output logic [7:0] data_in,
  output logic       pkt_valid,
  output logic       tx_busy,
  output logic       done,
  output logic       err
);
  state_t state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [1:0] addr;
  logic [7:0] parity;
  logic [7:0] rd_data;
  logic [7:0] hdr;
  logic wr_en;
  assign wr_en = state == S_LOAD && pay_valid && pay_ready;
  assign hdr = make_header(addr, len);
  tx_payload_buf #(.MAX_LEN(MAX_LEN), .AW(LEN_W)) u_buf (
    .clk(clk),
    .wr_en(wr_en),
    .wr_addr(cnt),
    .wr_data(pay_data),
    .rd_addr(cnt),
    .rd_data(rd_data)
  );
  // during transmit, cnt points at the next byte to fetch so data_in can stay registered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      len <= '0;
      cnt <= '0;
      addr <= '0;
      parity <= '0;
      data_in <= '0;
      pkt_valid <= 1'b0;
      pay_ready <= 1'b0;
      tx_busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            if (dest_addr == INVALID_ADDR || pay_len == '0) err <= 1'b1;
            else begin
              addr <= dest_addr;
              len <= pay_len;
              cnt <= '0;
              parity <= '0;
              pay_ready <= 1'b1;
              tx_busy <= 1'b1;
              state <= S_LOAD;
            end
          end
        S_LOAD:
          if (wr_en) begin
            if (cnt == len - 1'b1) begin
              cnt <= '0;
              pay_ready <= 1'b0;
              data_in <= hdr;
              pkt_valid <= 1'b1;
              parity <= hdr;
              state <= S_HEADER;
            end else cnt <= cnt + 1'b1;
          end
        S_HEADER:
          if (!busy) begin
            data_in <= rd_data;
            cnt <= LEN_W'(1);
            state <= S_PAYLOAD;
          end
        S_PAYLOAD:
          if (!busy) begin
            parity <= parity ^ data_in;
            if (cnt == len) begin
              data_in <= parity ^ data_in;
              pkt_valid <= 1'b0;
              state <= S_PARITY;
            end else begin
              data_in <= rd_data;
              cnt <= cnt + 1'b1;
            end
          end
        S_PARITY:
          if (!busy) begin
            data_in <= '0;
            done <= 1'b1;
            state <= S_DONE;
          end
        S_DONE: begin
          tx_busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
